vector_division_folded: RTL and testbench

- Parametrised successor to the per-element vector divider used after the exp-mul stage (O-vector normalisation).
- Divides every element of a VEC_LEN vector by one shared denominator. Instead of VEC_LEN full dividers, it uses LANES iterative radix-2 dividers that are time-multiplexed over VEC_LEN/LANES passes.
- Adds what the flat version lacks: area/latency trade via LANES, signed saturation, divide-by-zero handling with status flags, and a full valid/ready handshake with output hold.

---
 rtl/vector_division_folded.sv | 159 +++++++++++++++
 tb/tb_vector_division_folded.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_division_folded.sv
// Divides each element of a signed vector by one shared denominator, folding the
// work onto LANES iterative restoring dividers over VEC_LEN/LANES passes.
module vector_division_folded #(
  parameter int VEC_LEN = 64,
  parameter int LANES   = 8,
  parameter int IN_W    = 16,
  parameter int OUT_W   = 16,
  parameter int OUT_F   = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     vld_in,
  output logic                     rdy_out,
  input  logic [VEC_LEN*IN_W-1:0]  num_in,
  input  logic [IN_W-1:0]          den_in,
  output logic                     vld_out,
  input  logic                     rdy_in,
  output logic [VEC_LEN*OUT_W-1:0] vec_out,
  output logic                     dbz_out,
  output logic                     sat_out,
  output logic [1:0]               state_dbg
);

  // Handshake: a vector is taken on any rising edge where vld_in && rdy_out; a
  // result is delivered on any rising edge where vld_out && rdy_in. vld_out and all
  // result outputs hold steady until that delivery edge.

  if (VEC_LEN % LANES != 0) begin : g_bad_cfg
    $error("VEC_LEN must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ITER, DONE} state_t;

  localparam int NPASS = VEC_LEN / LANES;
  localparam int PW    = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam int CW    = $clog2(OUT_W);
  // Wide enough for both the scaled numerator and |den| << (OUT_W-1).
  localparam int WW    = ((IN_W + OUT_F > IN_W + OUT_W - 1) ? IN_W + OUT_F : IN_W + OUT_W - 1) + 1;
  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};

  state_t                  state, state_nxt;
  logic [PW-1:0]           pass_q;
  logic [CW-1:0]           cnt_q;
  logic [VEC_LEN*IN_W-1:0] num_r;
  logic [IN_W-1:0]         den_r;
  logic [WW-1:0]           dsr;

  logic [WW-1:0]           rem   [LANES];
  logic [OUT_W-2:0]        quo   [LANES];
  logic                    neg   [LANES];
  logic                    fsat  [LANES];
  logic                    fzero [LANES];

  logic [IN_W-1:0]         n_el    [LANES];
  logic [IN_W-1:0]         n_mag   [LANES];
  logic [WW-1:0]           dvd     [LANES];
  logic                    ovf     [LANES];
  logic                    qbit    [LANES];
  logic [OUT_W-2:0]        quo_nxt [LANES];
  logic [OUT_W-1:0]        mag     [LANES];
  logic [OUT_W-1:0]        res     [LANES];
  logic [IN_W-1:0]         den_mag;
  logic                    den_zero;

  logic accept, last_iter, last_pass;

  assign rdy_out   = (state == IDLE) && reset;
  assign vld_out   = (state == DONE);
  assign state_dbg = state;
  assign accept    = vld_in && rdy_out;
  assign last_iter = (state == ITER) && (cnt_q == CW'(OUT_W-2));
  assign last_pass = (pass_q == PW'(NPASS-1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ITER;
      ITER:    if (last_iter) state_nxt = last_pass ? DONE : SETUP;
      DONE:    if (rdy_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    den_mag  = den_r[IN_W-1] ? (~den_r + IN_W'(1)) : den_r;
    den_zero = (den_r == '0);
    for (int l = 0; l < LANES; l++) begin
      n_el[l]    = num_r[(int'(pass_q)*LANES + l)*IN_W +: IN_W];
      n_mag[l]   = n_el[l][IN_W-1] ? (~n_el[l] + IN_W'(1)) : n_el[l];
      dvd[l]     = WW'(n_mag[l]) << OUT_F;
      ovf[l]     = dvd[l] >= (WW'(den_mag) << (OUT_W-1));
      qbit[l]    = rem[l] >= dsr;
      quo_nxt[l] = {quo[l][OUT_W-3:0], qbit[l]};
      mag[l]     = fzero[l] ? '0 : (fsat[l] ? MAX_POS : {1'b0, quo_nxt[l]});
      res[l]     = neg[l] ? (~mag[l] + OUT_W'(1)) : mag[l];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pass_q  <= '0;
      cnt_q   <= '0;
      num_r   <= '0;
      den_r   <= '0;
      dsr     <= '0;
      vec_out <= '0;
      dbz_out <= 1'b0;
      sat_out <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        rem[l]   <= '0;
        quo[l]   <= '0;
        neg[l]   <= 1'b0;
        fsat[l]  <= 1'b0;
        fzero[l] <= 1'b0;
      end
    end else begin
      if (accept) begin
        num_r   <= num_in;
        den_r   <= den_in;
        pass_q  <= '0;
        dbz_out <= 1'b0;
        sat_out <= 1'b0;
      end
      case (state)
        SETUP: begin
          cnt_q <= '0;
          dsr   <= WW'(den_mag) << (OUT_W-2);
          if (den_zero) dbz_out <= 1'b1;
          for (int l = 0; l < LANES; l++) begin
            rem[l]   <= dvd[l];
            quo[l]   <= '0;
            neg[l]   <= n_el[l][IN_W-1] ^ den_r[IN_W-1];
            fzero[l] <= (n_mag[l] == '0);
            fsat[l]  <= (n_mag[l] != '0) && (den_zero || ovf[l]);
            if ((n_mag[l] != '0) && (den_zero || ovf[l])) sat_out <= 1'b1;
          end
        end
        ITER: begin
          cnt_q <= cnt_q + CW'(1);
          dsr   <= dsr >> 1;
          for (int l = 0; l < LANES; l++) begin
            if (qbit[l]) rem[l] <= rem[l] - dsr;
            quo[l] <= quo_nxt[l];
            if (last_iter) vec_out[(int'(pass_q)*LANES + l)*OUT_W +: OUT_W] <= res[l];
          end
          if (last_iter && !last_pass) pass_q <= pass_q + PW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_division_folded.sv
// Scoreboard bench for vector_division_folded: directed scenarios plus random
// vectors on LANES=2, and LANES=4 / LANES=1 instances checked against a reference model.
module tb_vector_division_folded;

  localparam int VEC_LEN = 4;
  localparam int IN_W    = 16;
  localparam int OUT_W   = 16;
  localparam int OUT_F   = 8;
  localparam int NW      = VEC_LEN*IN_W;
  localparam int VW      = VEC_LEN*OUT_W;
  localparam int EW      = VW + 2;
  localparam longint MAXV = (longint'(1) << (OUT_W-1)) - 1;

  // ---------------- clock / reset ----------------
  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic rst_sw = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- main DUT (LANES=2) ----------------
  logic          vld_in = 1'b0, rdy_out, vld_out, rdy_in = 1'b1, dbz_out, sat_out;
  logic [NW-1:0] num_in = '0;
  logic [IN_W-1:0] den_in = '0;
  logic [VW-1:0] vec_out;
  logic [1:0]    state_dbg;

  vector_division_folded #(.VEC_LEN(VEC_LEN), .LANES(2), .IN_W(IN_W), .OUT_W(OUT_W), .OUT_F(OUT_F)) dut (
    .clock(clock), .reset(reset), .vld_in(vld_in), .rdy_out(rdy_out), .num_in(num_in),
    .den_in(den_in), .vld_out(vld_out), .rdy_in(rdy_in), .vec_out(vec_out),
    .dbz_out(dbz_out), .sat_out(sat_out), .state_dbg(state_dbg));

  // ---------------- scoreboard bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  int acc_cyc = 0;
  logic vld_prev = 1'b0;
  logic rand_bp = 1'b0;
  logic [EW-1:0] mon_e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division truncating toward zero, clamped symmetrically.
  function automatic logic [EW-1:0] model(input logic [NW-1:0] n, input logic [IN_W-1:0] d);
    logic [VW-1:0] v;
    logic sat;
    longint nv, dv, q;
    v = '0;
    sat = 1'b0;
    dv = longint'($signed(d));
    for (int i = 0; i < VEC_LEN; i++) begin
      nv = longint'($signed(n[i*IN_W +: IN_W]));
      if (dv == 0) begin
        q = (nv > 0) ? MAXV : ((nv < 0) ? -MAXV : 0);
        if (nv != 0) sat = 1'b1;
      end else begin
        q = (nv * (longint'(1) << OUT_F)) / dv;
        if (q > MAXV) begin q = MAXV; sat = 1'b1; end
        else if (q < -MAXV) begin q = -MAXV; sat = 1'b1; end
      end
      v[i*OUT_W +: OUT_W] = q[OUT_W-1:0];
    end
    return {(dv == 0), sat, v};
  endfunction

  function automatic logic [IN_W-1:0] rand_elem();
    logic [IN_W-1:0] s;
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return '0;
      3: begin
        s = 16'($urandom_range(1, 15));
        return ($urandom_range(0, 1) == 1) ? (~s + 16'd1) : s;
      end
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [NW-1:0] rand_vec();
    logic [NW-1:0] v;
    for (int i = 0; i < VEC_LEN; i++) v[i*IN_W +: IN_W] = rand_elem();
    return v;
  endfunction

  function automatic logic [IN_W-1:0] rand_den();
    logic [IN_W-1:0] s;
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 16'h8000;
      2, 3: begin
        s = 16'($urandom_range(1, 8));
        return ($urandom_range(0, 1) == 1) ? (~s + 16'd1) : s;
      end
      4: return 16'($urandom_range(256, 4096));
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [NW-1:0] pack(input int e0, input int e1, input int e2, input int e3);
    return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (vld_out && !vld_prev) chk("latency", 128'(cyc - acc_cyc), 128'(32));
    if (vld_out && rdy_in) begin
      if (exp_q.size() == 0) chk("unexpected_out", 128'(vld_out), 128'(0));
      else begin
        mon_e = exp_q.pop_front();
        chk("vec", 128'(vec_out), 128'(mon_e[VW-1:0]));
        chk("flags", 128'({dbz_out, sat_out}), 128'(mon_e[VW+1:VW]));
      end
    end
    vld_prev = vld_out;
  end

  always @(posedge clock) begin
    #1;
    if (rand_bp) rdy_in = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [NW-1:0] n, input logic [IN_W-1:0] d, input bit expect_out);
    int t;
    t = 0;
    @(posedge clock); #1;
    while (!rdy_out && t < 500) begin @(posedge clock); #1; t++; end
    if (!rdy_out) chk("rdy_timeout", 128'(rdy_out), 128'(1));
    else begin
      num_in = n;
      den_in = d;
      vld_in = 1'b1;
      acc_cyc = cyc + 1;
      if (expect_out) exp_q.push_back(model(n, d));
      @(posedge clock); #1;
      vld_in = 1'b0;
    end
  endtask

  task automatic wait_vld();
    int t;
    t = 0;
    @(negedge clock);
    while (!vld_out && t < 300) begin @(negedge clock); t++; end
    if (!vld_out) chk("vld_timeout", 128'(vld_out), 128'(1));
  endtask

  task automatic run_dir(input string name, input logic [NW-1:0] n, input logic [IN_W-1:0] d,
                         input logic [VW-1:0] ev, input logic [1:0] ef);
    send(n, d, 1'b1);
    wait_vld();
    chk({name, "_vec"}, 128'(vec_out), 128'(ev));
    chk({name, "_flags"}, 128'({dbz_out, sat_out}), 128'(ef));
    @(negedge clock);
    chk({name, "_vld_drop"}, 128'({vld_out, rdy_out}), 128'(2'b01));
  endtask

  task automatic idle_window(input string name, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin @(negedge clock); seen = seen | vld_out; end
    chk(name, 128'(seen), 128'(0));
  endtask

  // ---------------- config sweep: LANES=4 and LANES=1 ----------------
  for (genvar k = 0; k < 2; k++) begin : g_sw
    localparam int SL   = (k == 0) ? 4 : 1;
    localparam int SLAT = (VEC_LEN/SL)*OUT_W;
    localparam int NV   = 8;
    logic s_vin = 1'b0, s_rdy_out, s_vld_out, s_rin = 1'b1, s_dbz, s_sat;
    logic [NW-1:0] s_num = '0;
    logic [IN_W-1:0] s_den = '0;
    logic [VW-1:0] s_vec;
    logic [1:0] s_state;
    logic [EW-1:0] sq[$];
    logic [EW-1:0] s_e;
    int s_acc = 0;
    int npop = 0;
    logic sprev = 1'b0;
    logic done = 1'b0;

    vector_division_folded #(.VEC_LEN(VEC_LEN), .LANES(SL), .IN_W(IN_W), .OUT_W(OUT_W), .OUT_F(OUT_F)) u_sw (
      .clock(clock), .reset(rst_sw), .vld_in(s_vin), .rdy_out(s_rdy_out), .num_in(s_num),
      .den_in(s_den), .vld_out(s_vld_out), .rdy_in(s_rin), .vec_out(s_vec),
      .dbz_out(s_dbz), .sat_out(s_sat), .state_dbg(s_state));

    always @(posedge clock) begin
      #1;
      s_rin = ($urandom_range(0, 2) != 0);
    end

    initial begin
      int t;
      @(posedge rst_sw);
      for (int v = 0; v < NV; v++) begin
        t = 0;
        @(posedge clock); #1;
        while (!s_rdy_out && t < 500) begin @(posedge clock); #1; t++; end
        if (!s_rdy_out) begin
          chk($sformatf("sw%0d_rdy_timeout", k), 128'(s_rdy_out), 128'(1));
          break;
        end
        s_num = rand_vec();
        s_den = rand_den();
        s_vin = 1'b1;
        s_acc = cyc + 1;
        sq.push_back(model(s_num, s_den));
        @(posedge clock); #1;
        s_vin = 1'b0;
      end
    end

    always @(negedge clock) begin
      if (s_vld_out && !sprev) chk($sformatf("sw%0d_latency", k), 128'(cyc - s_acc), 128'(SLAT));
      if (s_vld_out && s_rin) begin
        if (sq.size() == 0) chk($sformatf("sw%0d_unexpected", k), 128'(s_vld_out), 128'(0));
        else begin
          s_e = sq.pop_front();
          chk($sformatf("sw%0d_vec", k), 128'(s_vec), 128'(s_e[VW-1:0]));
          chk($sformatf("sw%0d_flags", k), 128'({s_dbz, s_sat}), 128'(s_e[VW+1:VW]));
          npop++;
          if (npop == NV) done = 1'b1;
        end
      end
      sprev = s_vld_out;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [VW-1:0] exp_h;
    int t;
    #1 reset = 1'b0;
    rst_sw = 1'b0;
    #10;
    chk("reset_rdy", 128'(rdy_out), 128'(0));
    chk("reset_outs", 128'({vld_out, dbz_out, sat_out, vec_out}), 128'(0));
    #10 rst_sw = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;
    #1 chk("reset_release_rdy", 128'(rdy_out), 128'(1));

    run_dir("basic", pack(3, -3, 1, -1), 16'd2, 64'hFF80_0080_FE80_0180, 2'b00);
    run_dir("trunc", pack(1, -1, 2, 7), 16'd3, 64'h0255_00AA_FFAB_0055, 2'b00);
    run_dir("sat", pack(32767, -32768, 128, 0), 16'd1, 64'h0000_7FFF_8001_7FFF, 2'b01);
    run_dir("dbz", pack(5, -5, 0, 1), 16'd0, 64'h7FFF_0000_8001_7FFF, 2'b11);

    // Backpressure: result held while rdy_in is low; a vld_in pulse must be ignored.
    @(posedge clock); #1;
    rdy_in = 1'b0;
    num_in = rand_vec();
    den_in = 16'($urandom_range(1, 64));
    exp_h = model(num_in, den_in)[VW-1:0];
    send(num_in, den_in, 1'b1);
    wait_vld();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clock);
      chk("bp_hold", 128'({vld_out, rdy_out, vec_out}), 128'({1'b1, 1'b0, exp_h}));
      @(posedge clock); #1;
      vld_in = (i == 3);
      if (i == 3) num_in = rand_vec();
    end
    vld_in = 1'b0;
    rdy_in = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("bp_release", 128'(vld_out), 128'(0));
    idle_window("bp_no_spurious", 60);

    // Reset in the middle of a vector: outputs clear at once, nothing is delivered.
    send(rand_vec(), 16'd5, 1'b0);
    while (cyc < acc_cyc + 12) begin @(posedge clock); #1; end
    reset = 1'b0;
    #1 chk("rst_async", 128'({rdy_out, vld_out, dbz_out, sat_out, vec_out}), 128'(0));
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    #1 chk("rst_rdy_after", 128'(rdy_out), 128'(1));
    idle_window("rst_no_out", 80);
    run_dir("post_rst", pack(3, -3, 1, -1), 16'd2, 64'hFF80_0080_FE80_0180, 2'b00);

    // Random vectors with random backpressure.
    rand_bp = 1'b1;
    repeat (12) send(rand_vec(), rand_den(), 1'b1);
    rand_bp = 1'b0;
    @(posedge clock); #1;
    rdy_in = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(negedge clock); t++; end
    if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 128'(0));

    t = 0;
    while (!(g_sw[0].done && g_sw[1].done) && t < 5000) begin @(negedge clock); t++; end
    if (!(g_sw[0].done && g_sw[1].done))
      chk("sweep_timeout", 128'({g_sw[1].done, g_sw[0].done}), 128'(2'b11));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
